// File: rtl/vga_pkg.sv
// vga_pkg: shared VGA timing defaults, mix modes, region decode and raw sync bundle
package vga_pkg;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP = 33;
  localparam bit MIX_OR = 1'b0;
  localparam bit MIX_PRIO = 1'b1;
  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} vga_region_t;
  typedef struct packed {
    logic hs;
    logic vs;
    logic act;
  } vga_raw_t;
  function automatic vga_region_t region_of(input int c, input int act, input int fp, input int sy);
    return c < act ? ACTIVE : c < act + fp ? FP : c < act + fp + sy ? SYNC : BP;
  endfunction
endpackage

// File: rtl/vga_layer_mixer.sv
// vga_layer_mixer: combinational OR / lowest-index-priority reduction over colour layers
module vga_layer_mixer
  import vga_pkg::*;
#(
  parameter int NUM_LAYERS = 2,
  parameter int COLOR_W = 12,
  parameter bit MIX_MODE = MIX_OR,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
)(
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_data_i,
  input  logic [NUM_LAYERS-1:0]         layer_vis_i,
  output logic [COLOR_W-1:0]            color_o
);
  logic [COLOR_W-1:0] or_c, prio_c;
  // walk layers high to low so the lowest visible index is the last priority write
  always_comb begin
    or_c = '0;
    prio_c = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      or_c = or_c | (layer_vis_i[i] ? layer_data_i[i*COLOR_W +: COLOR_W] : '0);
      prio_c = layer_vis_i[i] ? layer_data_i[i*COLOR_W +: COLOR_W] : prio_c;
    end
    color_o = ~|layer_vis_i ? BG_COLOR : MIX_MODE == MIX_PRIO ? prio_c : or_c;
  end
endmodule

// File: rtl/vga_timing_mixer.sv
// vga_timing_mixer: programmable VGA timing with pixel-clock enable and layer compositor
module vga_timing_mixer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP = DEF_V_BP,
  parameter int CLK_DIV = 2,
  parameter bit SYNC_POL = 1'b0,
  parameter int CNT_W = 10,
  parameter int COLOR_W = 12,
  parameter int NUM_LAYERS = 2,
  parameter int LAYER_LAT = 1,
  parameter bit MIX_MODE = MIX_OR,
  parameter logic [COLOR_W-1:0] BG_COLOR = '0
)(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          en,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_data,
  input  logic [NUM_LAYERS-1:0]         layer_vis,
  output logic                          pix_ce,
  output logic [CNT_W-1:0]              x_pos,
  output logic [CNT_W-1:0]              y_pos,
  output logic                          in_active,
  output logic                          line_start,
  output logic                          frame_start,
  output logic                          hsync,
  output logic                          vsync,
  output logic                          de,
  output logic [COLOR_W-1:0]            color_out
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] H_MAX = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_MAX = CNT_W'(V_TOTAL - 1);
  if (H_TOTAL > 2**CNT_W || V_TOTAL > 2**CNT_W) begin : g_size_chk
    $error("vga_timing_mixer: line or frame total does not fit CNT_W");
  end
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] h_q, h_d, v_q, v_d, x_q, y_q;
  logic tick, pix_ce_q, act_q, ls_q, fs_q, hs_q, vs_q, de_q;
  logic [COLOR_W-1:0] color_q, mix_color;
  vga_raw_t raw, tail;
  // pixel tick, next raster position and raw sync/active of the current position
  always_comb begin
    tick = en && div_q == DIV_W'(CLK_DIV - 1);
    div_d = tick ? '0 : en ? div_q + 1'b1 : div_q;
    h_d = h_q == H_MAX ? '0 : h_q + 1'b1;
    v_d = h_q != H_MAX ? v_q : v_q == V_MAX ? '0 : v_q + 1'b1;
    raw = '{hs: region_of(int'(h_q), H_ACTIVE, H_FP, H_SYNC) == SYNC,
            vs: region_of(int'(v_q), V_ACTIVE, V_FP, V_SYNC) == SYNC,
            act: region_of(int'(h_q), H_ACTIVE, H_FP, H_SYNC) == ACTIVE &&
                 region_of(int'(v_q), V_ACTIVE, V_FP, V_SYNC) == ACTIVE};
  end
  // divider runs only while enabled; raster counters step on each tick
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div_q <= '0;
      h_q <= '0;
      v_q <= '0;
    end else begin
      div_q <= div_d;
      if (tick) begin
        h_q <= h_d;
        v_q <= v_d;
      end
    end
  // publish the coordinate being generated together with its strobes
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pix_ce_q <= 1'b0;
      x_q <= '0;
      y_q <= '0;
      act_q <= 1'b0;
      ls_q <= 1'b0;
      fs_q <= 1'b0;
    end else begin
      pix_ce_q <= tick;
      if (tick) begin
        x_q <= h_q;
        y_q <= v_q;
        act_q <= raw.act;
        ls_q <= h_q == '0;
        fs_q <= h_q == '0 && v_q == '0;
      end
    end
  for (genvar i = 0; i < LAYER_LAT; i++) begin : g_dly
    vga_raw_t q;
    if (i == 0) begin : g_head
      // first stage captures raw timing alongside the published coordinate
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (tick) q <= raw;
    end else begin : g_tail
      // later stages shift one pixel tick per stage
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) q <= '0;
        else if (tick) q <= g_dly[i-1].q;
    end
  end
  assign tail = g_dly[LAYER_LAT-1].q;
  vga_layer_mixer #(
    .NUM_LAYERS(NUM_LAYERS),
    .COLOR_W(COLOR_W),
    .MIX_MODE(MIX_MODE),
    .BG_COLOR(BG_COLOR)
  ) u_mix (
    .layer_data_i(layer_data),
    .layer_vis_i(layer_vis),
    .color_o(mix_color)
  );
  // blank while halted, otherwise emit delayed timing with the freshly sampled layer colour
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      de_q <= 1'b0;
      color_q <= '0;
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
    end else if (!en) begin
      de_q <= 1'b0;
      color_q <= '0;
      hs_q <= ~SYNC_POL;
      vs_q <= ~SYNC_POL;
    end else if (tick) begin
      de_q <= tail.act;
      color_q <= tail.act ? mix_color : '0;
      hs_q <= tail.hs ? SYNC_POL : ~SYNC_POL;
      vs_q <= tail.vs ? SYNC_POL : ~SYNC_POL;
    end
  assign pix_ce = pix_ce_q;
  assign x_pos = x_q;
  assign y_pos = y_q;
  assign in_active = act_q;
  assign line_start = ls_q;
  assign frame_start = fs_q;
  assign hsync = hs_q;
  assign vsync = vs_q;
  assign de = de_q;
  assign color_out = color_q;
endmodule

// File: tb/tb_vga_timing_mixer.sv
// tb_vga_timing_mixer: two configurations against a pixel-index arithmetic model
`define WAITC(c) begin n = 0; do begin @(negedge clk); n++; end while (!(c) && n < 5000); chk("wait_bound", int'(n < 5000), 1); end
module tb_vga_timing_mixer;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2, VA = 4, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB;
  localparam int DIV [2] = '{3, 1};
  localparam int LAT [2] = '{3, 1};
  localparam bit POL [2] = '{1'b0, 1'b1};
  localparam bit MIX [2] = '{1'b1, 1'b0};
  localparam logic [11:0] BG [2] = '{12'h00F, 12'h000};
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0;
  logic [35:0] layer_data = '0;
  logic [2:0] layer_vis = '0;
  logic pix_ce [2], in_active [2], line_start [2], frame_start [2], hsync [2], vsync [2], de [2];
  logic [4:0] x_pos [2], y_pos [2];
  logic [11:0] color_out [2];
  int n_pass = 0, n_total = 0;
  bit cmp_on = 1'b0;
  int ecnt [2], ticks [2];
  logic m_pix [2], m_act [2], m_ls [2], m_fs [2], m_hs [2], m_vs [2], m_de [2];
  logic [4:0] m_x [2], m_y [2];
  logic [11:0] m_col [2];

  always #5 clk = ~clk;

  for (genvar i = 0; i < 2; i++) begin : g_dut
    vga_timing_mixer #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
      .CLK_DIV(DIV[i]), .SYNC_POL(POL[i]), .CNT_W(5), .COLOR_W(12), .NUM_LAYERS(3),
      .LAYER_LAT(LAT[i]), .MIX_MODE(MIX[i]), .BG_COLOR(BG[i])
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .layer_data(layer_data), .layer_vis(layer_vis),
      .pix_ce(pix_ce[i]), .x_pos(x_pos[i]), .y_pos(y_pos[i]), .in_active(in_active[i]),
      .line_start(line_start[i]), .frame_start(frame_start[i]), .hsync(hsync[i]),
      .vsync(vsync[i]), .de(de[i]), .color_out(color_out[i])
    );
  end

  task automatic chk(input string nm, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
  endtask

  function automatic logic [11:0] mixf(input bit prio, input logic [11:0] bg, input logic [35:0] data, input logic [2:0] vis);
    logic [11:0] r;
    r = '0;
    if (vis == 3'b000) return bg;
    for (int i = 0; i < 3; i++)
      if (vis[i]) begin
        if (prio) return data[i*12 +: 12];
        r = r | data[i*12 +: 12];
      end
    return r;
  endfunction

  function automatic bit is_act(input int x, input int y);
    return x < HA && y < VA;
  endfunction

  // model: pixel p is the p-th tick since reset; outputs show pixel p-LAT
  always @(posedge clk or negedge rst_n) begin
    int p, q, qx, qy;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        ecnt[d] = 0; ticks[d] = 0; m_pix[d] = 0; m_x[d] = '0; m_y[d] = '0; m_act[d] = 0;
        m_ls[d] = 0; m_fs[d] = 0; m_de[d] = 0; m_col[d] = '0; m_hs[d] = !POL[d]; m_vs[d] = !POL[d];
      end else if (!en) begin
        m_pix[d] = 0; m_de[d] = 0; m_col[d] = '0; m_hs[d] = !POL[d]; m_vs[d] = !POL[d];
      end else begin
        m_pix[d] = (ecnt[d] % DIV[d]) == DIV[d] - 1;
        ecnt[d]++;
        if (m_pix[d]) begin
          p = ticks[d];
          ticks[d]++;
          m_x[d] = 5'(p % HT);
          m_y[d] = 5'((p / HT) % VT);
          m_act[d] = is_act(p % HT, (p / HT) % VT);
          m_ls[d] = m_x[d] == 0;
          m_fs[d] = m_x[d] == 0 && m_y[d] == 0;
          q = p - LAT[d];
          if (q < 0) begin
            m_de[d] = 0; m_col[d] = '0; m_hs[d] = !POL[d]; m_vs[d] = !POL[d];
          end else begin
            qx = q % HT;
            qy = (q / HT) % VT;
            m_de[d] = is_act(qx, qy);
            m_col[d] = m_de[d] ? mixf(MIX[d], BG[d], layer_data, layer_vis) : 12'h000;
            m_hs[d] = (qx >= HA + HF && qx < HA + HF + HS) ? POL[d] : !POL[d];
            m_vs[d] = (qy >= VA + VF && qy < VA + VF + VS) ? POL[d] : !POL[d];
          end
        end
      end
    end
  end

  always @(negedge clk)
    if (cmp_on)
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("pix_ce[%0d]", d), int'(pix_ce[d]), int'(m_pix[d]));
        chk($sformatf("x_pos[%0d]", d), int'(x_pos[d]), int'(m_x[d]));
        chk($sformatf("y_pos[%0d]", d), int'(y_pos[d]), int'(m_y[d]));
        chk($sformatf("in_active[%0d]", d), int'(in_active[d]), int'(m_act[d]));
        chk($sformatf("line_start[%0d]", d), int'(line_start[d]), int'(m_ls[d]));
        chk($sformatf("frame_start[%0d]", d), int'(frame_start[d]), int'(m_fs[d]));
        chk($sformatf("hsync[%0d]", d), int'(hsync[d]), int'(m_hs[d]));
        chk($sformatf("vsync[%0d]", d), int'(vsync[d]), int'(m_vs[d]));
        chk($sformatf("de[%0d]", d), int'(de[d]), int'(m_de[d]));
        chk($sformatf("color[%0d]", d), int'(color_out[d]), int'(m_col[d]));
      end

  task automatic rand_run(input int cycles, input int en_low_odds);
    repeat (cycles) begin
      @(negedge clk);
      layer_data = 36'({$urandom(), $urandom()});
      layer_vis = 3'($urandom());
      en = $urandom_range(0, en_low_odds) != 0;
    end
    @(negedge clk);
    en = 1'b1;
  endtask

  initial begin
    int n, k;
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_x", int'(x_pos[d]), 0);
      chk("rst_pix_ce", int'(pix_ce[d]), 0);
      chk("rst_de", int'(de[d]), 0);
      chk("rst_color", int'(color_out[d]), 0);
      chk("rst_hsync", int'(hsync[d]), int'(!POL[d]));
    end
    rst_n = 1'b1;
    en = 1'b1;
    layer_data = {12'h00F, 12'h0F0, 12'hF00};
    layer_vis = 3'b011;
    `WAITC(pix_ce[0])
    chk("first_tick_clks", n, 3);
    chk("first_x", int'(x_pos[0]), 0);
    chk("first_y", int'(y_pos[0]), 0);
    chk("first_frame_start", int'(frame_start[0]), 1);
    `WAITC(pix_ce[0] && line_start[0])
    chk("line_period_clks", n, 45);
    `WAITC(pix_ce[1] && frame_start[1])
    `WAITC(pix_ce[1] && frame_start[1])
    chk("frame_period_clks", n, 120);
    `WAITC(pix_ce[0] && de[0])
    chk("prio_both_vis", int'(color_out[0]), 12'hF00);
    `WAITC(pix_ce[1] && de[1])
    chk("or_both_vis", int'(color_out[1]), 12'hFF0);
    layer_vis = 3'b010;
    `WAITC(pix_ce[0] && de[0])
    chk("prio_vis1_only", int'(color_out[0]), 12'h0F0);
    `WAITC(pix_ce[1] && de[1])
    chk("or_vis1_only", int'(color_out[1]), 12'h0F0);
    layer_vis = 3'b000;
    `WAITC(pix_ce[0] && de[0])
    chk("prio_bg", int'(color_out[0]), 12'h00F);
    `WAITC(pix_ce[1] && de[1])
    chk("or_bg", int'(color_out[1]), 12'h000);
    `WAITC(pix_ce[0] && !de[0])
    chk("blank_color", int'(color_out[0]), 12'h000);
    `WAITC(pix_ce[0] && hsync[0])
    `WAITC(!hsync[0])
    `WAITC(hsync[0])
    chk("hsync_width_clks", n, 9);
    `WAITC(pix_ce[0] && line_start[0] && y_pos[0] == 5'd1)
    k = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (pix_ce[0]) k++;
    end while (!de[0] && n < 5000);
    chk("de_latency_ticks", k, 3);
    `WAITC(pix_ce[0] && x_pos[0] == 5'd14)
    chk("hsync_in_sync", int'(hsync[0]), 0);
    en = 1'b0;
    repeat (50) @(negedge clk);
    chk("hold_x", int'(x_pos[0]), 14);
    chk("hold_hsync_inactive", int'(hsync[0]), 1);
    chk("hold_de", int'(de[0]), 0);
    chk("hold_pix_ce", int'(pix_ce[0]), 0);
    en = 1'b1;
    `WAITC(pix_ce[0])
    chk("resume_clks", n, 3);
    chk("resume_x", int'(x_pos[0]), 0);
    rand_run(2500, 15);
    `WAITC(pix_ce[0] && x_pos[0] == 5'd7 && y_pos[0] == 5'd2)
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_rst_x", int'(x_pos[d]), 0);
      chk("async_rst_y", int'(y_pos[d]), 0);
      chk("async_rst_de", int'(de[d]), 0);
      chk("async_rst_color", int'(color_out[d]), 0);
      chk("async_rst_hsync", int'(hsync[d]), int'(!POL[d]));
      chk("async_rst_vsync", int'(vsync[d]), int'(!POL[d]));
      chk("async_rst_pix_ce", int'(pix_ce[d]), 0);
      chk("async_rst_line_start", int'(line_start[d]), 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rand_run(600, 31);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
